// File: rtl/vie_mdu_ctrl_pkg.sv
// vie_mdu_ctrl_pkg: shared op codes, FSM state encoding and helpers for the MDU sequencer
//   MDU_OP_*     request op codes carried on req_op
//   mdu_state_e  sequencer states IDLE/PREP/CALC/FIX
//   abs_if       magnitude of a value when it is treated as signed
package vie_mdu_ctrl_pkg;
    localparam int MDU_OP_W = 3;
    typedef logic [MDU_OP_W-1:0] mdu_op_t;
    localparam mdu_op_t MDU_OP_MULT  = 3'd0;
    localparam mdu_op_t MDU_OP_MULTU = 3'd1;
    localparam mdu_op_t MDU_OP_DIV   = 3'd2;
    localparam mdu_op_t MDU_OP_DIVU  = 3'd3;
    localparam mdu_op_t MDU_OP_MTHI  = 3'd4;
    localparam mdu_op_t MDU_OP_MTLO  = 3'd5;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PREP = 2'd1, ST_CALC = 2'd2, ST_FIX = 2'd3} mdu_state_e;
    function automatic logic [31:0] abs_if(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/vie_mdu_ctrl_if.sv
// vie_mdu_ctrl_if: execute-stage <-> MDU request/response bundle
//   master (execute stage): req_valid, req_op, req_v1, req_v2, flush out; req_ready, busy_o, done_o, hi_o, lo_o in
//   slave  (MDU)          : the reverse
interface vie_mdu_ctrl_if;
    import vie_mdu_ctrl_pkg::*;
    logic        req_valid;
    mdu_op_t     req_op;
    logic [31:0] req_v1;
    logic [31:0] req_v2;
    logic        flush;
    logic        req_ready;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    modport master (output req_valid, req_op, req_v1, req_v2, flush, input req_ready, busy_o, done_o, hi_o, lo_o);
    modport slave  (input req_valid, req_op, req_v1, req_v2, flush, output req_ready, busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/vie_mdu_ctrl_dp.sv
// vie_mdu_ctrl_dp: 64-bit iterative shift-add multiply / restoring divide datapath
//   clock, reset      clock and async active-low reset
//   init              load {0, a} and latch divisor/multiplicand b
//   step              one iteration (mul: shift-add right, div: restoring subtract left)
//   mul               1 = multiply, 0 = divide
//   neg_q, neg_r      sign fix for product/quotient and remainder
//   res_hi, res_lo    sign-corrected result, combinational from the working register
module vie_mdu_ctrl_dp (
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        step,
    input  logic        mul,
    input  logic        neg_q,
    input  logic        neg_r,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    logic [63:0] p, p_nxt, p_neg;
    logic [31:0] d, diff;
    logic [32:0] sum, rem;
    logic        ge;
    always_comb begin
        sum   = {1'b0, p[63:32]} + {1'b0, d};
        rem   = {p[63:32], p[31]};
        ge    = rem >= {1'b0, d};
        // when the subtract succeeds the difference is below d, so 32 bits hold it
        diff  = rem[31:0] - d;
        p_nxt = mul ? (p[0] ? {sum, p[31:1]} : {1'b0, p[63:1]})
                    : (ge ? {diff, p[30:0], 1'b1} : {rem[31:0], p[30:0], 1'b0});
        p_neg = -p;
        res_hi = mul ? (neg_q ? p_neg[63:32] : p[63:32]) : (neg_r ? -p[63:32] : p[63:32]);
        res_lo = mul ? (neg_q ? p_neg[31:0] : p[31:0]) : (neg_q ? -p[31:0] : p[31:0]);
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            p <= '0;
            d <= '0;
        end else if (init) begin
            p <= {32'd0, a};
            d <= b;
        end else if (step) begin
            p <= p_nxt;
        end
endmodule

// File: rtl/vie_mdu_ctrl.sv
// vie_mdu_ctrl: sequencer for the shared multiply/divide unit, owns architectural HI/LO
//   clock, reset  clock and async active-low reset
//   bus           slave side of vie_mdu_ctrl_if (request handshake, flush, busy/done, HI/LO)
module vie_mdu_ctrl
    import vie_mdu_ctrl_pkg::*;
#(
    parameter int ITER_W = 5
) (
    input logic           clock,
    input logic           reset,
    vie_mdu_ctrl_if.slave bus
);
    mdu_state_e        state, state_nxt;
    logic [1:0]        op;
    logic [31:0]       v1, v2, hi, lo, res_hi, res_lo;
    logic [ITER_W-1:0] cnt;
    logic              neg_q, neg_r, divz;
    logic              accept, is_mul, sgn, div_zero, done;
    always_comb begin
        accept   = bus.req_valid & bus.req_ready;
        is_mul   = ~op[1];
        sgn      = ~op[0];
        div_zero = ~is_mul & (v2 == '0);
        done     = (state == ST_FIX) & ~bus.flush;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= ST_IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (bus.flush) state_nxt = ST_IDLE;
        else
            case (state)
                ST_IDLE: state_nxt = (accept && !bus.req_op[2]) ? ST_PREP : ST_IDLE;
                ST_PREP: state_nxt = div_zero ? ST_FIX : ST_CALC;
                ST_CALC: state_nxt = &cnt ? ST_FIX : ST_CALC;
                default: state_nxt = ST_IDLE;
            endcase
    end
    always_comb begin
        bus.req_ready = reset & (state == ST_IDLE) & ~bus.flush;
        bus.busy_o    = state != ST_IDLE;
        bus.done_o    = done;
        bus.hi_o      = hi;
        bus.lo_o      = lo;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            op    <= '0;
            v1    <= '0;
            v2    <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            divz  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                op <= bus.req_op[1:0];
                v1 <= bus.req_v1;
                v2 <= bus.req_v2;
            end
            if (accept && bus.req_op == MDU_OP_MTHI) hi <= bus.req_v1;
            if (accept && bus.req_op == MDU_OP_MTLO) lo <= bus.req_v1;
            if (state == ST_PREP) begin
                neg_q <= sgn & (v1[31] ^ v2[31]);
                neg_r <= sgn & v1[31];
                divz  <= div_zero;
                cnt   <= '0;
            end
            if (state == ST_CALC) cnt <= cnt + 1'b1;
            // divide-by-zero bypasses the datapath and its sign fix entirely
            if (done) begin
                hi <= divz ? v1 : res_hi;
                lo <= divz ? '1 : res_lo;
            end
        end
    vie_mdu_ctrl_dp u_dp (
        .clock (clock),
        .reset (reset),
        .init  (state == ST_PREP),
        .step  (state == ST_CALC),
        .mul   (is_mul),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .a     (abs_if(sgn, v1)),
        .b     (abs_if(sgn, v2)),
        .res_hi(res_hi),
        .res_lo(res_lo)
    );
endmodule

// File: tb/tb_vie_mdu_ctrl.sv
// tb_vie_mdu_ctrl: directed self-checking bench for vie_mdu_ctrl
module tb_vie_mdu_ctrl;
    import vie_mdu_ctrl_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vie_mdu_ctrl_if bus ();
    vie_mdu_ctrl #(.ITER_W(5)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_v1    = a;
        bus.req_v2    = b;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        bus.req_v1    = $urandom;
        bus.req_v2    = $urandom;
    endtask
    task automatic run(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
        int nb = 0;
        int nd = 0;
        issue(op, a, b);
        for (int k = 0; k < 100 && bus.busy_o; k++) begin
            nb++;
            if (bus.done_o) nd++;
            @(negedge clock);
        end
        chk({tag, " hi"}, bus.hi_o, exp_hi);
        chk({tag, " lo"}, bus.lo_o, exp_lo);
        chk({tag, " busy_cycles"}, nb, exp_busy);
        chk({tag, " done_pulses"}, nd, 1);
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_v1    = '0;
        bus.req_v2    = '0;
        bus.flush     = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst hi", bus.hi_o, 0);
        chk("rst lo", bus.lo_o, 0);
        chk("rst busy", bus.busy_o, 0);
        chk("rst done", bus.done_o, 0);
        chk("rst ready", bus.req_ready, 0);
        reset = 1'b1;
        #1 chk("ready after rst", bus.req_ready, 1);
        @(negedge clock);
        run("multu max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        run("mult -7x3", MDU_OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        run("div -7/2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        run("div ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
        run("div 7/-2", MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34);
        run("divu 100/0", MDU_OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 2);
        run("div -5/0", MDU_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 2);
        run("divu 100/7", MDU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
        issue(MDU_OP_MTHI, 32'h1234, 32'h0);
        chk("mthi hi", bus.hi_o, 32'h1234);
        chk("mthi lo", bus.lo_o, 32'd14);
        chk("mthi busy", bus.busy_o, 0);
        chk("mthi done", bus.done_o, 0);
        issue(MDU_OP_MTLO, 32'h5678, 32'h0);
        chk("mtlo lo", bus.lo_o, 32'h5678);
        chk("mtlo hi", bus.hi_o, 32'h1234);
        issue(MDU_OP_DIVU, 32'd100, 32'd7);
        repeat (19) @(negedge clock);
        chk("flush pre busy", bus.busy_o, 1);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = MDU_OP_MTHI;
        bus.req_v1    = 32'hDEAD_BEEF;
        #1 chk("flush ready", bus.req_ready, 0);
        @(posedge clock);
        @(negedge clock);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush busy", bus.busy_o, 0);
        chk("flush done", bus.done_o, 0);
        chk("flush hi", bus.hi_o, 32'h1234);
        chk("flush lo", bus.lo_o, 32'h5678);
        #1 chk("flush ready after", bus.req_ready, 1);
        @(negedge clock);
        issue(MDU_OP_MULTU, 32'd5, 32'd6);
        repeat (33) @(negedge clock);
        chk("fix done", bus.done_o, 1);
        bus.flush = 1'b1;
        #1 chk("fix flush done", bus.done_o, 0);
        @(posedge clock);
        @(negedge clock);
        bus.flush = 1'b0;
        chk("fix flush hi", bus.hi_o, 32'h1234);
        chk("fix flush lo", bus.lo_o, 32'h5678);
        chk("fix flush busy", bus.busy_o, 0);
        issue(MDU_OP_MULT, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        chk("mid busy", bus.busy_o, 1);
        reset = 1'b0;
        #1;
        chk("arst hi", bus.hi_o, 0);
        chk("arst lo", bus.lo_o, 0);
        chk("arst busy", bus.busy_o, 0);
        chk("arst done", bus.done_o, 0);
        chk("arst ready", bus.req_ready, 0);
        @(negedge clock);
        reset = 1'b1;
        run("multu 5x6", MDU_OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 34);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
